// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Holds the auto-repeat state encoding and the counter width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Defaults assume a 50 MHz clock: 10 ms debounce, 0.5 s to first repeat, 10 repeats/s.
  localparam int DEF_DEB_CYCLES = 500000;
  localparam int DEF_RPT_DELAY  = 25000000;
  localparam int DEF_RPT_PERIOD = 5000000;

  function automatic int cnt_width(input int deb, input int dly, input int per);
    int m;
    m = deb;
    if (dly > m) begin
      m = dly;
    end else begin
      m = m;
    end
    if (per > m) begin
      m = per;
    end else begin
      m = m;
    end
    if (m < 2) begin
      return 1;
    end else begin
      return $clog2(m);
    end
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchronizer, debounce filter, press/release pulses
// and the auto-repeat state machine.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter int CNT_W      = cnt_width(DEF_DEB_CYCLES, DEF_RPT_DELAY, DEF_RPT_PERIOD)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic rpt_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(RPT_PERIOD - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic             sync1_q;
  logic             sync2_q;
  logic             pressed_s;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [CNT_W-1:0] deb_cnt_d;
  logic             level_q;
  logic             level_d;
  logic             accept_s;
  logic             rise_s;
  logic             fall_s;
  rpt_state_e       state_q;
  rpt_state_e       state_d;
  logic [CNT_W-1:0] rpt_cnt_q;
  logic [CNT_W-1:0] rpt_cnt_d;
  logic             rpt_pulse_s;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Raw button is asynchronous; sync flops reset to the released level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    accept_s  = 1'b0;
    if (pressed_s == level_q) begin
      deb_cnt_d = CNT_ZERO;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_d = CNT_ZERO;
      level_d   = pressed_s;
      accept_s  = 1'b1;
    end else begin
      deb_cnt_d = sat_inc(deb_cnt_q);
    end
  end

  assign rise_s = accept_s & pressed_s;
  assign fall_s = accept_s & ~pressed_s;

  // A release or disabling repeat always wins, so no repeat pulse can collide with a release.
  always_comb begin
    state_d     = state_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_pulse_s = 1'b0;
    if (fall_s || !rpt_en_i) begin
      state_d   = IDLE;
      rpt_cnt_d = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          rpt_cnt_d = CNT_ZERO;
          if (rise_s) begin
            state_d = DELAY;
          end else begin
            state_d = IDLE;
          end
        end
        DELAY: begin
          if (rpt_cnt_q == DELAY_LAST) begin
            state_d     = REPEAT;
            rpt_cnt_d   = CNT_ZERO;
            rpt_pulse_s = 1'b1;
          end else begin
            rpt_cnt_d = sat_inc(rpt_cnt_q);
          end
        end
        REPEAT: begin
          if (rpt_cnt_q == PERIOD_LAST) begin
            rpt_cnt_d   = CNT_ZERO;
            rpt_pulse_s = 1'b1;
          end else begin
            rpt_cnt_d = sat_inc(rpt_cnt_q);
          end
        end
        default: begin
          state_d   = IDLE;
          rpt_cnt_d = CNT_ZERO;
        end
      endcase
    end
  end

  assign press_d   = rise_s | rpt_pulse_s;
  assign release_d = fall_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_cnt_q <= CNT_ZERO;
      level_q   <= 1'b0;
      state_q   <= IDLE;
      rpt_cnt_q <= CNT_ZERO;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounced, auto-repeating push-button front end for N_BTN active-low buttons.
// Channels are independent copies of btn_channel.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN      = 2,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] BTN,
  input  logic             RPT_EN,
  output logic [N_BTN-1:0] LEVEL,
  output logic [N_BTN-1:0] PRESS,
  output logic [N_BTN-1:0] RELEASE
);

  localparam int CNT_W = cnt_width(DEB_CYCLES, RPT_DELAY, RPT_PERIOD);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk_i     (CLK),
      .rst_ni    (RST_N),
      .btn_i     (BTN[g]),
      .rpt_en_i  (RPT_EN),
      .level_o   (LEVEL[g]),
      .press_o   (PRESS[g]),
      .release_o (RELEASE[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed timing checks plus random stimulus
// compared every cycle against a run-length / elapsed-time reference model.
module tb_btn_conditioner;

  localparam int N   = 2;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic         CLK;
  logic         RST_N;
  logic [N-1:0] BTN;
  logic         RPT_EN;
  logic [N-1:0] LEVEL;
  logic [N-1:0] PRESS;
  logic [N-1:0] RELEASE;

  int n_tests = 0;
  int n_fail  = 0;

  btn_conditioner #(
    .N_BTN(N), .DEB_CYCLES(DEB), .RPT_DELAY(RD), .RPT_PERIOD(RP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN(BTN), .RPT_EN(RPT_EN),
    .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a change is accepted once the (2-cycle delayed) input has
  // differed from the accepted level for DEB consecutive edges; repeats fire at
  // RD edges after acceptance and every RP edges thereafter.
  typedef struct {
    logic lvl;
    int   run;
    bit   armed;
    int   age;
    logic press;
    logic rel;
  } ch_t;

  ch_t          m_ch [N];
  logic [N-1:0] m_d1;
  logic [N-1:0] m_d2;

  function automatic ch_t ch_reset();
    ch_t r;
    r.lvl = 1'b0; r.run = 0; r.armed = 1'b0; r.age = 0; r.press = 1'b0; r.rel = 1'b0;
    return r;
  endfunction

  function automatic ch_t ch_step(input ch_t s, input logic raw_late, input logic rpt_en);
    ch_t  n;
    logic v;
    bit   rise;
    bit   fall;
    n = s; v = ~raw_late; rise = 1'b0; fall = 1'b0;
    n.press = 1'b0;
    n.rel   = 1'b0;
    if (v !== s.lvl) begin
      n.run = s.run + 1;
      if (n.run == DEB) begin
        n.run = 0; n.lvl = v; rise = v; fall = ~v;
      end
    end else begin
      n.run = 0;
    end
    if (fall || !rpt_en) begin
      n.armed = 1'b0;
    end else if (rise) begin
      n.armed = 1'b1; n.age = 0;
    end else if (s.armed) begin
      n.age = s.age + 1;
      if (n.age == RD || (n.age > RD && (n.age - RD) % RP == 0)) n.press = 1'b1;
    end
    n.press = n.press | rise;
    n.rel   = fall;
    return n;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_d1 <= '1;
      m_d2 <= '1;
      for (int c = 0; c < N; c++) m_ch[c] <= ch_reset();
    end else begin
      for (int c = 0; c < N; c++) m_ch[c] <= ch_step(m_ch[c], m_d2[c], RPT_EN);
      m_d2 <= m_d1;
      m_d1 <= BTN;
    end
  end

  always @(negedge CLK) begin
    for (int c = 0; c < N; c++) begin
      check($sformatf("model LEVEL[%0d]", c),   LEVEL[c],   m_ch[c].lvl);
      check($sformatf("model PRESS[%0d]", c),   PRESS[c],   m_ch[c].press);
      check($sformatf("model RELEASE[%0d]", c), RELEASE[c], m_ch[c].rel);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    BTN = '1;
    repeat (12) tick();
  endtask

  int first;
  int cnt_a;
  int cnt_b;
  int cnt_c;
  int cnt_d;
  int rel_edge;
  int press_edges[$];
  int run_left[N];

  initial begin
    RST_N = 1'b0; BTN = '1; RPT_EN = 1'b0;
    repeat (3) tick();
    check("reset LEVEL", LEVEL, 0);
    check("reset PRESS", PRESS, 0);
    check("reset RELEASE", RELEASE, 0);
    RST_N = 1'b1;
    repeat (5) tick();

    // Clean press, no repeat
    BTN[0] = 1'b0; first = 0; cnt_a = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (LEVEL[0] && first == 0) first = i;
      cnt_a += int'(PRESS[0]);
    end
    check("clean level edge", first, 6);
    check("clean press count", cnt_a, 1);
    BTN[0] = 1'b1; cnt_b = 0;
    repeat (10) begin tick(); cnt_b += int'(RELEASE[0]); end
    check("clean release count", cnt_b, 1);
    settle();

    // Bounce on channel 1
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (3) begin
      BTN[1] = 1'b0;
      repeat (2) begin tick(); cnt_a += int'(LEVEL[1]); cnt_b += int'(PRESS[1]); cnt_c += int'(RELEASE[1]); end
      BTN[1] = 1'b1;
      repeat (3) begin tick(); cnt_a += int'(LEVEL[1]); cnt_b += int'(PRESS[1]); cnt_c += int'(RELEASE[1]); end
    end
    check("bounce level", cnt_a, 0);
    check("bounce press", cnt_b, 0);
    check("bounce release", cnt_c, 0);
    settle();

    // Auto-repeat
    RPT_EN = 1'b1; BTN[0] = 1'b0; press_edges.delete(); rel_edge = 0; cnt_b = 0;
    for (int i = 1; i <= 55; i++) begin
      tick();
      if (PRESS[0]) press_edges.push_back(i);
      if (RELEASE[0]) begin rel_edge = i; cnt_b++; end
      if (i == 40) BTN[0] = 1'b1;
    end
    check("repeat count", press_edges.size(), 11);
    check("repeat first", (press_edges.size() > 0) ? press_edges[0] : -1, 6);
    check("repeat second", (press_edges.size() > 1) ? press_edges[1] : -1, 16);
    check("repeat third", (press_edges.size() > 2) ? press_edges[2] : -1, 19);
    check("repeat last", (press_edges.size() > 0) ? press_edges[press_edges.size()-1] : -1, 43);
    check("repeat release edge", rel_edge, 46);
    check("repeat release count", cnt_b, 1);
    RPT_EN = 1'b0;
    settle();

    // Simultaneous press
    BTN = '0; first = 0; cnt_a = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (PRESS == 2'b11) first = i;
      if (PRESS == 2'b01 || PRESS == 2'b10) cnt_a++;
    end
    check("simul press edge", first, 6);
    check("simul lone press", cnt_a, 0);
    settle();

    // Reset during REPEAT with button held
    RPT_EN = 1'b1; BTN[0] = 1'b0;
    repeat (20) tick();
    check("pre-reset level", LEVEL[0], 1);
    RST_N = 1'b0;
    #1;
    check("mid reset LEVEL", LEVEL, 0);
    check("mid reset PRESS", PRESS, 0);
    check("mid reset RELEASE", RELEASE, 0);
    tick(); tick();
    RST_N = 1'b1; first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (PRESS[0] && first == 0) first = i;
    end
    check("re-accept press edge", first, 6);
    RPT_EN = 1'b0;
    settle();

    // Ten press/release pairs on both channels
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int p = 0; p < 10; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        BTN = (ph == 0) ? 2'b00 : 2'b11;
        repeat (8) begin
          tick();
          cnt_a += int'(PRESS[0]); cnt_b += int'(PRESS[1]);
          cnt_c += int'(RELEASE[0]); cnt_d += int'(RELEASE[1]);
        end
      end
    end
    repeat (10) begin
      tick();
      cnt_a += int'(PRESS[0]); cnt_b += int'(PRESS[1]);
      cnt_c += int'(RELEASE[0]); cnt_d += int'(RELEASE[1]);
    end
    check("pairs press0", cnt_a, 10);
    check("pairs press1", cnt_b, 10);
    check("pairs release0", cnt_c, 10);
    check("pairs release1", cnt_d, 10);

    // Random stimulus, checked by the model every cycle
    RPT_EN = 1'b1;
    for (int c = 0; c < N; c++) run_left[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int c = 0; c < N; c++) begin
        if (run_left[c] == 0) begin
          BTN[c] = ~BTN[c];
          run_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                    : int'($urandom_range(1, 10));
        end else begin
          run_left[c]--;
        end
      end
      if ($urandom_range(0, 199) == 0) RPT_EN = ~RPT_EN;
      if ($urandom_range(0, 999) == 0) begin
        RST_N = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
      end
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
